// File: rtl/fn_sw_pkg.sv
// Shared definitions for the fn_sw checker: state encoding and run length default.
package fn_sw_pkg;

  localparam int NUM_VEC_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One stimulus/response vector as seen on the checker inputs.
  typedef struct packed {
    logic a;
    logic b;
    logic sel;
    logic y;
  } vec_t;

endpackage

// File: rtl/fn_sw_ref.sv
// Reference model of fn_sw: AND when sel is high, XOR otherwise.
module fn_sw_ref (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y_exp
);

  assign y_exp = sel ? (a & b) : (a ^ b);

endmodule

// File: rtl/fn_sw_chk.sv
// Run-based checker for a combinational fn_sw: counts accepted vectors and
// mismatches, and captures the first failing vector of each run.
module fn_sw_chk
  import fn_sw_pkg::*;
#(
  parameter int NUM_VEC = NUM_VEC_DEF,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vld,
  input  logic             a,
  input  logic             b,
  input  logic             sel,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [3:0]       first_err_vec
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0] ERR_MAX  = '1;

  state_t state, state_nxt;
  logic   y_exp;
  logic   accept;
  logic   enter_run;
  logic   mism;

  fn_sw_ref u_ref (
    .a    (a),
    .b    (b),
    .sel  (sel),
    .y_exp(y_exp)
  );

  // start only matters outside RUN; vld only matters inside RUN
  assign accept    = (state == ST_RUN) && vld;
  assign enter_run = (state != ST_RUN) && start;
  assign mism      = (y != y_exp);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: DONE is entered on the edge accepting the last vector
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (accept && vec_cnt == LAST_IDX) state_nxt = ST_DONE;
      ST_DONE: if (start) state_nxt = ST_RUN;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Counters and first-error capture; err_cnt never wraps back to 0, so
  // err_cnt == 0 reliably marks the first mismatch of the run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_cnt       <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      first_err_vec <= '0;
    end else if (enter_run) begin
      vec_cnt       <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      first_err_vec <= '0;
    end else if (accept) begin
      vec_cnt <= vec_cnt + 1'b1;
      if (mism) begin
        if (err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
        if (err_cnt == '0) begin
          first_err_idx <= vec_cnt;
          first_err_vec <= {a, b, sel, y};
        end
      end
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);
  assign pass = done && (err_cnt == '0);

endmodule
